// File: rtl/tdm_deinterleaver.sv
// Rebuilds a parallel LANES-word frame from the round-robin serial lane stream.
// Optional build macro SOF_RESYNC_EN: din_sof realigns the lane select to lane 0.
module tdm_deinterleaver #(
  parameter int unsigned LANES = 12,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           din,
  input  logic                       din_valid,
  input  logic                       din_sof,
  output logic [LANES*WIDTH-1:0]     dout,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic [$clog2(LANES)-1:0]   sel,
  output logic                       overflow,
  output logic                       sync_err
);

  localparam int unsigned SEL_W   = $clog2(LANES);
  localparam int unsigned FRAME_W = LANES * WIDTH;

  logic [FRAME_W-1:0] asm_q;
  logic [FRAME_W-1:0] asm_d;
  logic [FRAME_W-1:0] dout_d;
  logic [SEL_W-1:0]   wr_lane;
  logic [SEL_W-1:0]   sel_d;
  logic               dout_valid_d;
  logic               overflow_d;
  logic               complete;

`ifdef SOF_RESYNC_EN
  logic sync_err_d;
`else
  logic unused_sof;
  assign unused_sof = din_sof;
  assign sync_err   = 1'b0;
`endif

  // Next-state: lane write, select advance, frame hand-off and overflow detection
  always_comb begin
    wr_lane      = sel;
    sel_d        = sel;
    asm_d        = asm_q;
    dout_d       = dout;
    dout_valid_d = dout_valid;
    overflow_d   = overflow;
    complete     = 1'b0;
`ifdef SOF_RESYNC_EN
    sync_err_d   = 1'b0;
    if (din_valid && din_sof) begin
      wr_lane    = '0;
      sync_err_d = (sel != '0);
    end
`endif
    if (din_valid) begin
      asm_d[wr_lane*WIDTH +: WIDTH] = din;
      complete = (wr_lane == SEL_W'(LANES - 1));
      sel_d    = complete ? '0 : wr_lane + SEL_W'(1);
    end
    // A completed frame can only replace dout once the previous one is taken
    if (complete) begin
      if (!dout_valid || dout_ready) begin
        dout_d       = asm_d;
        dout_valid_d = 1'b1;
      end else begin
        overflow_d   = 1'b1;
      end
    end else if (dout_valid && dout_ready) begin
      dout_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      asm_q      <= '0;
      sel        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      asm_q      <= asm_d;
      sel        <= sel_d;
      dout       <= dout_d;
      dout_valid <= dout_valid_d;
      overflow   <= overflow_d;
    end
  end

`ifdef SOF_RESYNC_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_err <= 1'b0;
    end else begin
      sync_err <= sync_err_d;
    end
  end
`endif

endmodule

// File: tb/tb_tdm_deinterleaver.sv
// Directed self-checking bench for tdm_deinterleaver (12 lanes x 8 bits).
module tb_tdm_deinterleaver;

  localparam int unsigned LANES = 12;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned FW    = LANES * WIDTH;

  logic          clk;
  logic          reset;
  logic [7:0]    din;
  logic          din_valid;
  logic          din_sof;
  logic [FW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic [3:0]    sel;
  logic          overflow;
  logic          sync_err;

  int n_cmp;
  int n_err;

  logic [7:0] fa [12];
  logic [7:0] fb [12];
  logic [7:0] fr [12];
  logic [7:0] fx [12];

  tdm_deinterleaver #(.LANES(LANES), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .din_valid  (din_valid),
    .din_sof    (din_sof),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .sel        (sel),
    .overflow   (overflow),
    .sync_err   (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [FW-1:0] pack(input logic [7:0] w [12]);
    logic [FW-1:0] f;
    f = '0;
    for (int k = 0; k < 12; k++) f[k*8 +: 8] = w[k];
    return f;
  endfunction

  function automatic logic [7:0] lane(input logic [FW-1:0] f, input int k);
    return f[k*8 +: 8];
  endfunction

  task automatic put(input logic [7:0] d, input logic sof);
    @(negedge clk);
    din       = d;
    din_valid = 1'b1;
    din_sof   = sof;
  endtask

  task automatic idle();
    @(negedge clk);
    din_valid = 1'b0;
    din_sof   = 1'b0;
  endtask

  task automatic send(input logic [7:0] w [12]);
    for (int i = 0; i < 12; i++) put(w[i], i == 0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    fa = '{8'h01, 8'h12, 8'h23, 8'h34, 8'h45, 8'h78, 8'h67, 8'h78, 8'h89, 8'h9A, 8'hAB, 8'hBC};
    fb = '{8'h15, 8'h27, 8'h30, 8'h46, 8'h54, 8'h50, 8'h77, 8'h87, 8'h98, 8'h60, 8'h88, 8'h90};
    fr = '{8'h31, 8'h12, 8'h53, 8'h34, 8'h45, 8'h87, 8'h26, 8'h78, 8'h45, 8'h23, 8'hAB, 8'hBC};
    reset = 1'b0; din = '0; din_valid = 1'b0; din_sof = 1'b0; dout_ready = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_sel", 128'(sel), 128'(0));
    check("rst_dout", 128'(dout), 128'(0));
    check("rst_dout_valid", 128'(dout_valid), 128'(0));
    check("rst_overflow", 128'(overflow), 128'(0));
    check("rst_sync_err", 128'(sync_err), 128'(0));
    reset = 1'b1;

    // single frame
    send(fa);
    idle();
    check("f1_valid", 128'(dout_valid), 128'(1));
    check("f1_lane0", 128'(lane(dout, 0)), 128'(8'h01));
    check("f1_lane5", 128'(lane(dout, 5)), 128'(8'h78));
    check("f1_lane11", 128'(lane(dout, 11)), 128'(8'hBC));
    check("f1_dout", 128'(dout), 128'(pack(fa)));
    check("f1_sel", 128'(sel), 128'(0));
    idle();
    check("f1_valid_drop", 128'(dout_valid), 128'(0));

    // gaps between words
    for (int i = 0; i < 12; i++) begin
      put(fa[i], i == 0);
      if (i < 11) begin
        repeat (3) idle();
        if (i == 3) check("gap_sel_hold", 128'(sel), 128'(4));
        if (i == 10) check("gap_no_early_valid", 128'(dout_valid), 128'(0));
      end
    end
    idle();
    check("gap_valid", 128'(dout_valid), 128'(1));
    check("gap_dout", 128'(dout), 128'(pack(fa)));
    idle();

    // backpressure with overflow
    dout_ready = 1'b0;
    send(fa);
    idle();
    check("bp_first_valid", 128'(dout_valid), 128'(1));
    check("bp_no_ovf_yet", 128'(overflow), 128'(0));
    send(fb);
    idle();
    check("bp_overflow", 128'(overflow), 128'(1));
    check("bp_dout_held", 128'(dout), 128'(pack(fa)));
    check("bp_valid_held", 128'(dout_valid), 128'(1));
    dout_ready = 1'b1;
    idle();
    check("bp_valid_drop", 128'(dout_valid), 128'(0));
    check("bp_ovf_sticky", 128'(overflow), 128'(1));

    // clear sticky overflow
    @(negedge clk);
    reset = 1'b0;
    #1 check("ovf_clear", 128'(overflow), 128'(0));
    @(negedge clk);
    reset = 1'b1;

    // back-to-back frames, no bubble
    send(fa);
    put(fb[0], 1'b1);
    check("b2b_first_valid", 128'(dout_valid), 128'(1));
    check("b2b_first_dout", 128'(dout), 128'(pack(fa)));
    for (int i = 1; i < 12; i++) put(fb[i], 1'b0);
    idle();
    check("b2b_second_valid", 128'(dout_valid), 128'(1));
    check("b2b_second_lane0", 128'(lane(dout, 0)), 128'(8'h15));
    check("b2b_second_dout", 128'(dout), 128'(pack(fb)));
    check("b2b_overflow", 128'(overflow), 128'(0));
    idle();

    // sof in mid-frame
    for (int i = 0; i < 5; i++) put(fa[i], i == 0);
    put(8'h32, 1'b1);
    idle();
`ifdef SOF_RESYNC_EN
    check("rs_sync_err", 128'(sync_err), 128'(1));
    check("rs_sel", 128'(sel), 128'(1));
    idle();
    check("rs_sync_err_pulse", 128'(sync_err), 128'(0));
    for (int i = 1; i < 12; i++) put(fa[i], 1'b0);
    idle();
    fx = fa;
    fx[0] = 8'h32;
    check("rs_valid", 128'(dout_valid), 128'(1));
    check("rs_lane0", 128'(lane(dout, 0)), 128'(8'h32));
    check("rs_dout", 128'(dout), 128'(pack(fx)));
`else
    check("rs_sync_err", 128'(sync_err), 128'(0));
    check("rs_sel", 128'(sel), 128'(6));
    for (int i = 6; i < 12; i++) put(fa[i], 1'b0);
    idle();
    fx = fa;
    fx[5] = 8'h32;
    check("rs_valid", 128'(dout_valid), 128'(1));
    check("rs_lane0", 128'(lane(dout, 0)), 128'(8'h01));
    check("rs_lane5", 128'(lane(dout, 5)), 128'(8'h32));
    check("rs_dout", 128'(dout), 128'(pack(fx)));
    check("rs_sync_err_late", 128'(sync_err), 128'(0));
`endif
    idle();

    // reset mid-frame with a pending frame and overflow
    dout_ready = 1'b0;
    send(fa);
    send(fb);
    for (int i = 0; i < 6; i++) put(fa[i], i == 0);
    @(negedge clk);
    din_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("mr_sel", 128'(sel), 128'(0));
    check("mr_dout_valid", 128'(dout_valid), 128'(0));
    check("mr_overflow", 128'(overflow), 128'(0));
    check("mr_dout", 128'(dout), 128'(0));
    @(negedge clk);
    reset = 1'b1;
    dout_ready = 1'b1;
    send(fr);
    idle();
    check("mr_clean_valid", 128'(dout_valid), 128'(1));
    check("mr_clean_lane0", 128'(lane(dout, 0)), 128'(8'h31));
    check("mr_clean_dout", 128'(dout), 128'(pack(fr)));
    check("mr_clean_ovf", 128'(overflow), 128'(0));
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
